// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, link offset and EX FSM states.
// Used by the ALU controller and alu_exec_unit.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_XOR  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_EQ   = 4'b1000,
    ALU_NE   = 4'b1001,
    ALU_LT   = 4'b1010,
    ALU_GE   = 4'b1011,
    ALU_LINK = 4'b1100,
    ALU_LTU  = 4'b1101,
    ALU_GEU  = 4'b1110,
    ALU_ILL  = 4'b1111
  } alu_op_e;

  localparam int ALU_LINK_OFFSET = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter for alu_exec_unit.
// Instantiated only when ALU_FAST_SHIFT_EN is undefined.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SHW    = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              left,
  input  logic              arith,
  input  logic [DATA_W-1:0] din,
  input  logic [SHW-1:0]    amt,
  output logic              last,
  output logic [DATA_W-1:0] work_nxt
);

  logic [DATA_W-1:0] work_q, work_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic              left_q, left_d;
  logic              arith_q, arith_d;

  always_comb begin
    if (left_q) begin
      work_nxt = {work_q[DATA_W-2:0], 1'b0};
    end else begin
      work_nxt = {arith_q & work_q[DATA_W-1], work_q[DATA_W-1:1]};
    end
  end

  assign last = (cnt_q == SHW'(1));

  always_comb begin
    work_d  = work_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    arith_d = arith_q;
    if (start) begin
      work_d  = din;
      cnt_d   = amt;
      left_d  = left;
      arith_d = arith;
    end else if (cnt_q != '0) begin
      work_d = work_nxt;
      cnt_d  = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked EX-stage ALU with registered result.
// ALU_FAST_SHIFT_EN selects a barrel shifter over the iterative one.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal
);

  localparam int SHW = $clog2(DATA_W);

  alu_state_e        state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;

  alu_op_e           op;
  logic [SHW-1:0]    amt;
  logic [DATA_W-1:0] op_res;
  logic              accept;

  assign op  = alu_op_e'(Operation);
  assign amt = src_b[SHW-1:0];

  assign in_ready  = (state_q == ST_IDLE) ||
                     ((state_q == ST_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_HOLD);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  always_comb begin
    op_res = '0;
    unique case (op)
      ALU_AND:  op_res = src_a & src_b;
      ALU_XOR:  op_res = src_a ^ src_b;
      ALU_OR:   op_res = src_a | src_b;
      ALU_ADD:  op_res = src_a + src_b;
      ALU_SUB:  op_res = src_a - src_b;
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:  op_res = src_a << amt;
      ALU_SRL:  op_res = src_a >> amt;
      ALU_SRA:  op_res = DATA_W'($signed(src_a) >>> amt);
`else
      // Only reached with amt == 0; longer shifts go iterative
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  op_res = src_a;
`endif
      ALU_EQ:   op_res[0] = (src_a == src_b);
      ALU_NE:   op_res[0] = (src_a != src_b);
      ALU_LT:   op_res[0] = ($signed(src_a) < $signed(src_b));
      ALU_GE:   op_res[0] = ($signed(src_a) >= $signed(src_b));
      ALU_LTU:  op_res[0] = (src_a < src_b);
      ALU_GEU:  op_res[0] = (src_a >= src_b);
      ALU_LINK: op_res = src_a + DATA_W'(ALU_LINK_OFFSET);
      ALU_ILL:  op_res = '0;
      default:  op_res = '0;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  logic              sh_start;
  logic              sh_last;
  logic [DATA_W-1:0] sh_nxt;

  assign sh_start = accept && is_shift(op) && (amt != '0);

  alu_shift_iter #(
    .DATA_W (DATA_W),
    .SHW    (SHW)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (sh_start),
    .left     (op == ALU_SLL),
    .arith    (op == ALU_SRA),
    .din      (src_a),
    .amt      (amt),
    .last     (sh_last),
    .work_nxt (sh_nxt)
  );
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
      if (sh_start) begin
        state_d   = ST_SHIFT;
        illegal_d = 1'b0;
      end else
`endif
      begin
        state_d   = ST_HOLD;
        result_d  = op_res;
        illegal_d = (op == ALU_ILL);
      end
    end else if ((state_q == ST_HOLD) && out_ready) begin
      state_d = ST_IDLE;
`ifndef ALU_FAST_SHIFT_EN
    end else if ((state_q == ST_SHIFT) && sh_last) begin
      state_d  = ST_HOLD;
      result_d = sh_nxt;
`endif
    end
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int total = 0;
  int bad   = 0;
  int lat;

`ifdef ALU_FAST_SHIFT_EN
  localparam int LAT_SRA4 = 1;
  localparam int LAT_SLL3 = 1;
`else
  localparam int LAT_SRA4 = 5;
  localparam int LAT_SLL3 = 4;
`endif

  alu_exec_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b);
    in_valid  = 1'b1;
    Operation = op;
    src_a     = a;
    src_b     = b;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    Operation = 4'h0;
    src_a     = '0;
    src_b     = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD wrap, then SUB back-to-back
    req(4'b0010, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_result", result, 32'h0);
    chk("add_zero", 32'(zero), 32'd1);
    req(4'b0011, 32'd5, 32'd7);
    @(negedge clk);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_zero", 32'(zero), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // SRA by 4 with junk in upper amount bits
    req(4'b0111, 32'h8000_0000, 32'h24);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
`ifndef ALU_FAST_SHIFT_EN
    chk("sra_busy_ready", 32'(in_ready), 32'd0);
    chk("sra_busy_valid", 32'(out_valid), 32'd0);
`endif
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("sra_latency", 32'(lat), 32'(LAT_SRA4));
    chk("sra_result", result, 32'hF800_0000);
    chk("sra_illegal", 32'(illegal), 32'd0);
    @(negedge clk);

    // compares, link, illegal
    req(4'b1010, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    chk("lt_result", result, 32'h1);
    req(4'b1101, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    chk("ltu_result", result, 32'h0);
    chk("ltu_zero", 32'(zero), 32'd1);
    req(4'b1100, 32'h100, 32'h0);
    @(negedge clk);
    chk("link_result", result, 32'h104);
    req(4'b1111, 32'h1234, 32'h5678);
    @(negedge clk);
    chk("ill_result", result, 32'h0);
    chk("ill_flag", 32'(illegal), 32'd1);
    req(4'b1011, 32'h1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("ge_result", result, 32'h1);
    chk("ge_illegal", 32'(illegal), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);

    // backpressure with queued AND
    out_ready = 1'b0;
    req(4'b0001, 32'hF0, 32'hFF);
    @(negedge clk);
    req(4'b0000, 32'hF0, 32'h0F);
    for (int i = 0; i < 3; i++) begin
      chk("bp_result", result, 32'h0F);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("and_valid", 32'(out_valid), 32'd1);
    chk("and_result", result, 32'h0);
    chk("and_zero", 32'(zero), 32'd1);
    @(negedge clk);
    chk("and_drain", 32'(out_valid), 32'd0);

    // reset during a long shift
    req(4'b0100, 32'h1, 32'd31);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'(out_valid), 32'd0);
    req(4'b0100, 32'h1, 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("sll_latency", 32'(lat), 32'(LAT_SLL3));
    chk("sll_result", result, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Handshaked execute unit that consumes the 4-bit `Operation` code produced by the ALU controller together with two source operands and returns a registered result. It sits in the EX stage between the ID/EX register and the EX/MEM register. Single-cycle ops complete in one cycle. Shifts run on an iterative one-bit-per-cycle shifter unless the fast-shift option is compiled in.

## Interface
- `DATA_W`, 32, operand/result width (power of two, ≥8)
- `clk` input 1 system clock, rising edge
- `rst_n` input 1 reset, asynchronous, active-low
- `in_valid` input 1 operation request
- `in_ready` output 1 unit can accept a request this cycle
- `Operation` input 4 op code (`alu_op_e`)
- `src_a` input DATA_W operand A
- `src_b` input DATA_W operand B / shift amount
- `out_valid` output 1 result available
- `out_ready` input 1 consumer takes result
- `result` output DATA_W registered result
- `zero` output 1 `result == 0`
- `illegal` output 1 op code 4'b1111 was executed

## Operation
- Encoding:
  - 0000 AND, 0001 XOR, 0010 ADD, 0011 SUB
  - 0100 SLL, 0101 SRL, 0110 OR, 0111 SRA
  - 1000 EQ, 1001 NE, 1010 LT (signed), 1011 GE (signed)
  - 1100 LINK (src_a+4), 1101 LTU, 1110 GEU, 1111 illegal
- Compares return 0 or 1 in bit 0, upper bits 0. Arithmetic is modulo 2^DATA_W.
- Shift amount is `src_b[$clog2(DATA_W)-1:0]`, upper bits ignored. SRA fills with `src_a[DATA_W-1]`.
- Illegal op: `result`=0, `illegal`=1, flagged with that result only.
- FSM has three states: IDLE, SHIFT, HOLD.
  - IDLE: `in_ready`=1. On accept, a non-shift op or a shift with amount 0 → HOLD with result registered. A shift with amount k>0 → SHIFT, with work=`src_a` and count=k.
  - SHIFT: `in_ready`=0. Each cycle shifts work by 1 and decrements count. When count reaches 0, the state goes to HOLD and `result` takes the final work value.
  - HOLD: `out_valid`=1. `in_ready`=`out_ready`. If `out_ready` and `in_valid` are both high, the new request is accepted as in IDLE (back-to-back). If only `out_ready` is high → IDLE. Otherwise hold: `result`, `zero` and `illegal` stay stable.
- Operand and op inputs are sampled only on accept (`in_valid && in_ready`).

## Timing
- Reset values: state IDLE; `out_valid`=0, `result`=0, `zero`=1, `illegal`=0. Count and work are 0.
- Reset assertion mid-SHIFT or mid-HOLD aborts the operation immediately; the pending result is lost.
- Latency from the accept cycle to `out_valid`:
  - non-shift op: 1 cycle
  - shift by k: 1+k cycles (k=0 → 1 cycle)
- Throughput: 1 op/cycle for non-shift ops while `out_ready` is held high.
- `out_valid` never drops without `out_ready`.
- `in_ready` is combinational from state and `out_ready`. It has no path from `in_valid`.

## Configuration
- `ALU_FAST_SHIFT_EN` defined: shifts use a single-cycle barrel shifter. The SHIFT state and count are removed, and every op has latency 1.
- `ALU_FAST_SHIFT_EN` undefined: iterative shifter as described above.
- Results are bit-identical in both builds; only latency differs.

## Structure
- `alu_pkg` holds the following, shared with the ALU controller:
  - `alu_op_e` (4-bit enum with the codes above)
  - `ALU_LINK_OFFSET` = 4
  - the FSM state typedef
- Sub-module `alu_shift_iter` holds the work register, count, direction/arith select, start/done. It is instantiated only when `ALU_FAST_SHIFT_EN` is undefined.

## Test plan
- After reset: `out_valid`=0, `result`=0, `zero`=1, `in_ready`=1.
- ADD 0xFFFFFFFF+0x00000001 with `out_ready`=1 → next cycle `result`=0, `zero`=1. SUB 5−7 → 0xFFFFFFFE.
- SRA 0x80000000 by src_b=0x24 (amount 4) → `result`=0xF8000000.
  - Iterative build: out_valid 5 cycles after accept, `in_ready`=0 meanwhile.
  - Fast build: 1 cycle.
- LT 0xFFFFFFFF vs 1 → 1. LTU on the same operands → 0. LINK 0x100 → 0x104. Op 1111 → `result`=0, `illegal`=1.
- Backpressure: hold `out_ready`=0 for 3 cycles after XOR 0xF0^0xFF. `result` stays 0x0F and `in_ready`=0. Then `out_ready`=1 with a queued AND → accepted the same cycle; next result 0x0 follows with no bubble.
- Assert `rst_n` low mid SLL 1 by 31 → immediately `out_valid`=0. After release, SLL 1 by 3 → 0x8.
